// File: rtl/prg_loader_pkg.sv
// -----------------------------------------------------------------------------
// ie_defs: shared definitions for the prg_loader program loader.
//   prg_ld_state_t      - loader FSM state encoding
//   PRG_LD_ERR_*        - 2-bit error codes reported on err_code
//   ld_accepts_bytes()  - states in which the byte stream is accepted
//   ld_frame_open()     - states in which a frame is in flight (idle timer runs)
//   ld_busy()           - states reported on busy
// -----------------------------------------------------------------------------
package ie_defs;

  typedef enum logic [3:0] {
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_VEC_LO,
    S_VEC_HI,
    S_DONE,
    S_ERR
  } prg_ld_state_t;

  localparam logic [1:0] PRG_LD_ERR_NONE    = 2'd0;
  localparam logic [1:0] PRG_LD_ERR_CSUM    = 2'd1;
  localparam logic [1:0] PRG_LD_ERR_TIMEOUT = 2'd2;

  localparam int unsigned PRG_LD_IDLE_W = 20;

  // Header, payload and checksum states take bytes from the stream.
  function automatic logic ld_accepts_bytes(input prg_ld_state_t s);
    return s inside {S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
  endfunction

  // A frame is open once its first byte has been taken; S_ADDR_LO is
  // excluded so an idle link never raises a timeout.
  function automatic logic ld_frame_open(input prg_ld_state_t s);
    return s inside {S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
  endfunction

  function automatic logic ld_busy(input prg_ld_state_t s);
    return !(s inside {S_ADDR_LO, S_DONE, S_ERR});
  endfunction

endpackage

// File: rtl/prg_loader_bus_mux.sv
// -----------------------------------------------------------------------------
// prg_loader_bus_mux: RAM write-port selector.
//   cpu_rst_n            in  : 0 -> loader owns RAM, 1 -> CPU owns RAM
//   ld_addr/wdata/we     in  : loader-side (registered) write port
//   cpu_addr/wdata/we    in  : CPU bus
//   mem_addr/wdata/we    out : RAM write port
// Purely combinational so the CPU sees RAM with no added latency once released.
// -----------------------------------------------------------------------------
module prg_loader_bus_mux (
  input  logic        cpu_rst_n,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  input  logic        ld_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we
);

  assign mem_addr  = cpu_rst_n ? cpu_addr  : ld_addr;
  assign mem_wdata = cpu_rst_n ? cpu_wdata : ld_wdata;
  assign mem_we    = cpu_rst_n ? cpu_we    : ld_we;

endmodule

// File: rtl/prg_loader.sv
// -----------------------------------------------------------------------------
// prg_loader: byte-stream program loader in front of cpu_6502.
//
// Holds the CPU in reset and owns the RAM write port while a frame
//   ADDR_LO ADDR_HI LEN_LO LEN_HI <LEN payload bytes> CSUM
// arrives on a valid/ready byte stream. Payload is written from the load
// address upward (wrapping at 16'hFFFF). The frame is accepted when the 8-bit
// sum of payload bytes plus CSUM is zero; then the CPU is released and the
// RAM port is handed to the CPU bus.
//
// Build option: define PRG_LOADER_VECTOR_EN to also write the load address
// into the reset vector (VEC_ADDR, VEC_ADDR+1) before release.
//
// Parameters:
//   VEC_ADDR        reset-vector low-byte address
//   TIMEOUT_CYCLES  max idle cycles between bytes inside a frame, 0 = none
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     pulse: abort and restart the load
//   in_valid/in_data/in_ready byte stream
//   cpu_addr/wdata/we         CPU bus
//   mem_addr/wdata/we         RAM write port
//   cpu_rst_n                 CPU reset (0 = held)
//   busy, done, err, err_code load status
// -----------------------------------------------------------------------------
module prg_loader
  import ie_defs::*;
#(
  parameter logic [15:0] VEC_ADDR       = 16'hFFFC,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [PRG_LD_IDLE_W-1:0] IDLE_LIMIT = PRG_LD_IDLE_W'(TIMEOUT_CYCLES);
  localparam logic                     TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  prg_ld_state_t state, state_next;
  logic [1:0]    err_code_next;

  logic [15:0]   load_addr;   // frame load address, also the vector value
  logic [15:0]   wr_ptr;      // next payload write address
  logic [15:0]   remaining;   // payload bytes still expected
  logic [7:0]    csum;        // running payload sum
  logic [PRG_LD_IDLE_W-1:0] idle_cnt;

  // Loader-side write port, registered so a handshake in cycle N writes in N+1.
  logic [15:0]   ld_addr;
  logic [7:0]    ld_wdata;
  logic          ld_we;

  logic          hs;
  logic          timeout_hit;

  assign in_ready = ld_accepts_bytes(state);
  assign hs       = in_valid & in_ready;
  assign busy     = ld_busy(state);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);

  // Fires on the cycle whose idle increment would reach the limit, so the
  // error state is entered exactly TIMEOUT_CYCLES cycles after the last byte.
  assign timeout_hit = TIMEOUT_EN && ld_frame_open(state) && !hs &&
                       ((idle_cnt + 1'b1) == IDLE_LIMIT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next    = state;
    err_code_next = err_code;

    if (start) begin
      state_next    = S_ADDR_LO;
      err_code_next = PRG_LD_ERR_NONE;
    end else if (timeout_hit) begin
      state_next    = S_ERR;
      err_code_next = PRG_LD_ERR_TIMEOUT;
    end else begin
      unique case (state)
        S_ADDR_LO: if (hs) state_next = S_ADDR_HI;
        S_ADDR_HI: if (hs) state_next = S_LEN_LO;
        S_LEN_LO:  if (hs) state_next = S_LEN_HI;
        S_LEN_HI: begin
          if (hs) begin
            // Length is complete only now: LEN_HI is on the bus, LEN_LO is held.
            if ({in_data, remaining[7:0]} == 16'd0) state_next = S_CSUM;
            else                                    state_next = S_DATA;
          end
        end
        S_DATA: begin
          if (hs && remaining == 16'd1) state_next = S_CSUM;
        end
        S_CSUM: begin
          if (hs) begin
            if (8'(csum + in_data) == 8'h00) begin
`ifdef PRG_LOADER_VECTOR_EN
              state_next = S_VEC_LO;
`else
              state_next = S_DONE;
`endif
            end else begin
              state_next    = S_ERR;
              err_code_next = PRG_LD_ERR_CSUM;
            end
          end
        end
        S_VEC_LO: state_next = S_VEC_HI;
        S_VEC_HI: state_next = S_DONE;
        S_DONE:   state_next = S_DONE;
        S_ERR:    state_next = S_ERR;
        default:  state_next = S_ADDR_LO;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, datapath and loader write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before this edge, independent of statement order.
    if (rst) begin
      state     <= S_ADDR_LO;
      err_code  <= PRG_LD_ERR_NONE;
      cpu_rst_n <= 1'b0;
      load_addr <= '0;
      wr_ptr    <= '0;
      remaining <= '0;
      csum      <= '0;
      idle_cnt  <= '0;
      ld_addr   <= '0;
      ld_wdata  <= '0;
      ld_we     <= 1'b0;
    end else begin
      state    <= state_next;
      err_code <= err_code_next;
      ld_we    <= 1'b0;

      // Release lags S_DONE by one cycle so the last loader write has landed
      // before the bus is handed to the CPU.
      cpu_rst_n <= (state == S_DONE) && !start;

      if (start) begin
        load_addr <= '0;
        wr_ptr    <= '0;
        remaining <= '0;
        csum      <= '0;
        idle_cnt  <= '0;
      end else begin
        if (ld_frame_open(state) && !hs) idle_cnt <= idle_cnt + 1'b1;
        else                             idle_cnt <= '0;

        unique case (state)
          S_ADDR_LO: if (hs) load_addr[7:0] <= in_data;
          S_ADDR_HI: begin
            if (hs) begin
              load_addr[15:8] <= in_data;
              wr_ptr          <= {in_data, load_addr[7:0]};
            end
          end
          S_LEN_LO: if (hs) remaining[7:0]  <= in_data;
          S_LEN_HI: if (hs) remaining[15:8] <= in_data;
          S_DATA: begin
            if (hs) begin
              ld_we     <= 1'b1;
              ld_addr   <= wr_ptr;
              ld_wdata  <= in_data;
              wr_ptr    <= wr_ptr + 16'd1;   // wraps 16'hFFFF -> 16'h0000
              remaining <= remaining - 16'd1;
              csum      <= csum + in_data;
            end
          end
          // Vector states are reachable only when PRG_LOADER_VECTOR_EN is
          // defined; otherwise this logic is dead and RAM outside the payload
          // is never touched.
          S_VEC_LO: begin
            ld_we    <= 1'b1;
            ld_addr  <= VEC_ADDR;
            ld_wdata <= load_addr[7:0];
          end
          S_VEC_HI: begin
            ld_we    <= 1'b1;
            ld_addr  <= VEC_ADDR + 16'd1;
            ld_wdata <= load_addr[15:8];
          end
          default: ;
        endcase
      end
    end
  end

  prg_loader_bus_mux u_bus_mux (
    .cpu_rst_n (cpu_rst_n),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_we     (ld_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

endmodule

// File: tb/tb_prg_loader.sv
// -----------------------------------------------------------------------------
// tb_prg_loader: directed self-checking bench for prg_loader.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge. A behavioural RAM (background 8'hEE) captures every mem_we write.
// Expectations follow the build: PRG_LOADER_VECTOR_EN adds the vector writes.
// -----------------------------------------------------------------------------
module tb_prg_loader;

`ifdef PRG_LOADER_VECTOR_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif
  localparam logic [7:0] BG = 8'hEE;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  logic [7:0]  ram [0:65535];
  int          wr_count;
  int          n_vec = 0;
  int          n_err = 0;

  typedef logic [7:0] byte_q_t[$];

  always #5 clk = ~clk;

  prg_loader #(
    .VEC_ADDR       (16'hFFFC),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  // RAM model: background fill, then capture writes on the rising edge.
  initial begin
    wr_count = 0;
    for (int i = 0; i < 65536; i++) ram[i] = BG;
    forever begin
      @(posedge clk);
      if (mem_we === 1'b1) begin
        ram[mem_addr] <= mem_wdata;
        wr_count      <= wr_count + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL send_byte_ready: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input byte_q_t f);
    for (int i = 0; i < f.size(); i++) send_byte(f[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (done !== 1'b1 && err !== 1'b1) begin
      n_err++;
      $display("FAIL %s_end: done=%b err=%b after %0d cycles, required one set", tag, done, err, n);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cpu_addr = 16'h1234; cpu_wdata = 8'h99; cpu_we = 1'b1;  // must not leak through
    repeat (3) @(negedge clk);
    n_vec++; if ({cpu_rst_n, in_ready, mem_we} !== 3'b010) begin n_err++;
      $display("FAIL reset_ctl: cpu_rst_n/in_ready/mem_we=%b required 010", {cpu_rst_n, in_ready, mem_we}); end
    n_vec++; if ({mem_addr, mem_wdata} !== 24'h0) begin n_err++;
      $display("FAIL reset_bus: mem_addr=%h mem_wdata=%h required 0000/00", mem_addr, mem_wdata); end
    n_vec++; if ({busy, done, err, err_code} !== 5'b0) begin n_err++;
      $display("FAIL reset_status: busy/done/err/err_code=%b required 00000", {busy, done, err, err_code}); end
    cpu_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_happy();
    byte_q_t hdr = '{8'h00, 8'h80, 8'h03, 8'h00};
    for (int i = 0; i < 4; i++) send_byte(hdr[i]);
    n_vec++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL happy_busy: busy=%b required 1", busy); end
    send_byte(8'hA9);
    // Registered write: handshake on the previous edge shows up now.
    n_vec++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h8000, 8'hA9}) begin n_err++;
      $display("FAIL happy_wr_latency: we/addr/data=%b/%h/%h required 1/8000/a9", mem_we, mem_addr, mem_wdata); end
    send_byte(8'h01);
    send_byte(8'hEA);
    send_byte(8'h6C);
    in_valid = 1'b0;
    repeat (VEC ? 2 : 0) @(negedge clk);
    n_vec++; if ({done, cpu_rst_n} !== 2'b10) begin n_err++;
      $display("FAIL happy_release_lag: done/cpu_rst_n=%b required 10", {done, cpu_rst_n}); end
    @(negedge clk);
    n_vec++; if ({done, cpu_rst_n, err, in_ready, busy} !== 5'b11000) begin n_err++;
      $display("FAIL happy_status: done/cpu_rst_n/err/in_ready/busy=%b required 11000", {done, cpu_rst_n, err, in_ready, busy}); end
    n_vec++; if ({ram[16'h8000], ram[16'h8001], ram[16'h8002]} !== 24'hA901EA) begin n_err++;
      $display("FAIL happy_payload: ram[8000..8002]=%h required a901ea", {ram[16'h8000], ram[16'h8001], ram[16'h8002]}); end
    n_vec++; if ({ram[16'hFFFC], ram[16'hFFFD]} !== (VEC ? 16'h0080 : {BG, BG})) begin n_err++;
      $display("FAIL happy_vector: ram[fffc..fffd]=%h required %h", {ram[16'hFFFC], ram[16'hFFFD]}, (VEC ? 16'h0080 : {BG, BG})); end
  endtask

  task automatic test_csum_fail();
    pulse_start();
    n_vec++; if ({cpu_rst_n, done, in_ready} !== 3'b001) begin n_err++;
      $display("FAIL start_clears: cpu_rst_n/done/in_ready=%b required 001", {cpu_rst_n, done, in_ready}); end
    send_frame('{8'h00, 8'h80, 8'h03, 8'h00, 8'hA9, 8'h01, 8'hEA, 8'h6D});
    n_vec++; if ({err, err_code, in_ready} !== 4'b1010) begin n_err++;
      $display("FAIL csum_err: err/err_code/in_ready=%b required 1010", {err, err_code, in_ready}); end
    repeat (5) @(negedge clk);
    n_vec++; if ({cpu_rst_n, done} !== 2'b00) begin n_err++;
      $display("FAIL csum_held: cpu_rst_n/done=%b required 00", {cpu_rst_n, done}); end
    n_vec++; if (ram[16'hFFFC] !== (VEC ? 8'h00 : BG)) begin n_err++;
      $display("FAIL csum_vector_untouched: ram[fffc]=%h required %h", ram[16'hFFFC], (VEC ? 8'h00 : BG)); end
  endtask

  task automatic test_wrap();
    pulse_start();
    // 11+22+33+44 = aa, so CSUM = 56.
    send_frame('{8'hFE, 8'hFF, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56});
    wait_end("wrap");
    @(negedge clk);
    n_vec++; if ({ram[16'hFFFE], ram[16'hFFFF], ram[16'h0000], ram[16'h0001]} !== 32'h11223344) begin n_err++;
      $display("FAIL wrap_payload: ram[fffe,ffff,0000,0001]=%h required 11223344",
               {ram[16'hFFFE], ram[16'hFFFF], ram[16'h0000], ram[16'h0001]}); end
    n_vec++; if ({done, err} !== 2'b10) begin n_err++;
      $display("FAIL wrap_done: done/err=%b required 10", {done, err}); end
  endtask

  task automatic test_zero_len();
    int wr0;
    pulse_start();
    wr0 = wr_count;
    send_frame('{8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
    wait_end("zero_len");
    repeat (2) @(negedge clk);
    n_vec++; if ((wr_count - wr0) != (VEC ? 2 : 0)) begin n_err++;
      $display("FAIL zero_len_writes: %0d writes, required %0d", wr_count - wr0, (VEC ? 2 : 0)); end
    n_vec++; if ({done, cpu_rst_n, ram[16'h0200]} !== {2'b11, BG}) begin n_err++;
      $display("FAIL zero_len_done: done/cpu_rst_n=%b ram[0200]=%h required 11/%h", {done, cpu_rst_n}, ram[16'h0200], BG); end
  endtask

  task automatic test_timeout();
    pulse_start();
    // Idle in S_ADDR_LO well past the limit: no frame open, no timeout.
    repeat (40) @(negedge clk);
    n_vec++; if ({err, in_ready, busy} !== 3'b010) begin n_err++;
      $display("FAIL idle_no_timeout: err/in_ready/busy=%b required 010", {err, in_ready, busy}); end
    send_frame('{8'h00, 8'h90, 8'h01, 8'h00});
    repeat (15) @(negedge clk);
    n_vec++; if ({err_code, busy} !== 3'b001) begin n_err++;
      $display("FAIL timeout_early: err_code=%0d busy=%b at 15 cycles, required 0/1", err_code, busy); end
    @(negedge clk);
    n_vec++; if ({err, err_code, cpu_rst_n} !== 4'b1100) begin n_err++;
      $display("FAIL timeout_hit: err/err_code/cpu_rst_n=%b at 16 cycles, required 1100", {err, err_code, cpu_rst_n}); end
  endtask

  task automatic test_restart_passthrough();
    pulse_start();
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h55); send_byte(8'h66);
    // Byte 77 collides with start and must be dropped.
    in_data = 8'h77;
    pulse_start();
    in_valid = 1'b0;
    n_vec++; if ({in_ready, busy, mem_we} !== 3'b100) begin n_err++;
      $display("FAIL restart_state: in_ready/busy/mem_we=%b required 100", {in_ready, busy, mem_we}); end
    repeat (2) @(negedge clk);
    n_vec++; if ({ram[16'h0300], ram[16'h0301], ram[16'h0302]} !== {8'h55, 8'h66, BG}) begin n_err++;
      $display("FAIL restart_writes: ram[0300..0302]=%h required 5566%h", {ram[16'h0300], ram[16'h0301], ram[16'h0302]}, BG); end
    // c0+de = 9e, so CSUM = 62.
    send_frame('{8'h00, 8'h03, 8'h02, 8'h00, 8'hC0, 8'hDE, 8'h62});
    wait_end("restart");
    @(negedge clk);
    n_vec++; if ({done, cpu_rst_n, ram[16'h0300], ram[16'h0301]} !== {2'b11, 16'hC0DE}) begin n_err++;
      $display("FAIL restart_load: done/cpu_rst_n=%b ram[0300..0301]=%h required 11/c0de", {done, cpu_rst_n}, {ram[16'h0300], ram[16'h0301]}); end
    cpu_addr = 16'h0300; cpu_wdata = 8'h5A; cpu_we = 1'b1;
    #1;
    n_vec++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0300, 8'h5A}) begin n_err++;
      $display("FAIL pass_bus: we/addr/data=%b/%h/%h required 1/0300/5a", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    cpu_we = 1'b0;
    n_vec++; if (ram[16'h0300] !== 8'h5A) begin n_err++;
      $display("FAIL pass_write: ram[0300]=%h required 5a", ram[16'h0300]); end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_csum_fail();
    test_wrap();
    test_zero_len();
    test_timeout();
    test_restart_passthrough();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prg_loader.md
# prg_loader

Byte-stream program loader sitting directly upstream of `cpu_6502`. It holds the CPU in reset and owns the system RAM port while a framed image arrives on a valid/ready byte stream from a host link (e.g. UART). It writes the image into RAM, verifies a checksum, optionally patches the reset vector, then releases the CPU and passes the CPU bus through to RAM.

## Interface
Parameters:
- `VEC_ADDR`, 16'hFFFC: reset-vector low-byte address; high byte is at `VEC_ADDR+1`.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle cycles between bytes inside a frame. 0 disables the timeout. Counter width is 20 bits.

Ports. One clock; reset is synchronous and active-high (`clk`, `rst`).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that aborts any activity and restarts the load.
- `in_valid` in 1: a stream byte is present.
- `in_data` in 8: stream byte.
- `in_ready` out 1: the loader accepts a byte this cycle.
- `cpu_addr` in 16, `cpu_wdata` in 8, `cpu_we` in 1: CPU bus.
- `mem_addr` out 16, `mem_wdata` out 8, `mem_we` out 1: RAM write port.
- `cpu_rst_n` out 1: 0 holds the CPU in reset; drives the CPU reset input.
- `busy` out 1: a frame is in progress.
- `done` out 1: the last load succeeded.
- `err` out 1: the last load failed.
- `err_code` out 2: 0 = none, 1 = checksum, 2 = timeout.

## Operation
- Frame format, in byte order: ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN payload bytes, CSUM.
- The checksum passes when the 8-bit sum of all payload bytes plus CSUM equals 8'h00.
- States: S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_VEC_LO, S_VEC_HI, S_DONE, S_ERR.
- Each header state advances on a handshake (`in_valid & in_ready`).
- S_LEN_HI goes to S_DATA. If the received length is 0, it goes straight to S_CSUM.
- In S_DATA, each accepted byte is written to the write pointer. The pointer starts at the load address and increments modulo 2^16, so a write past 16'hFFFF wraps to 16'h0000.
  - The remaining count decrements with each byte. Width: 16-bit count; LEN = 16'hFFFF loads 65535 bytes.
  - When the count reaches 0, the state goes to S_CSUM.
- S_CSUM: on the handshake the sum is checked.
  - Pass: go to S_VEC_LO if the vector macro is defined, otherwise to S_DONE.
  - Fail: go to S_ERR with `err_code` = 1.
- S_VEC_LO and S_VEC_HI each write one byte, with no stream handshake:
  - S_VEC_LO writes the load address low byte to `VEC_ADDR`.
  - S_VEC_HI writes the load address high byte to `VEC_ADDR+1`.
  - S_VEC_HI then goes to S_DONE.
- S_DONE: `cpu_rst_n` = 1, `done` = 1, `in_ready` = 0.
- S_ERR: `cpu_rst_n` = 0, `err` = 1, `in_ready` = 0.
  - Both S_DONE and S_ERR are left only by `start` or `rst`.
- `in_ready` = 1 in S_ADDR_LO through S_CSUM, and 0 otherwise.
- Timeout:
  - In S_ADDR_HI through S_CSUM, the idle counter increments each cycle that has no handshake, and clears on a handshake.
  - When the count reaches `TIMEOUT_CYCLES`, the state goes to S_ERR with `err_code` = 2.
  - S_ADDR_LO never times out, because no frame has started.
- Bus mux:
  - While `cpu_rst_n` = 0, the `mem_*` outputs come from the loader.
  - Otherwise `mem_*` equals `cpu_*`, combinationally.
- `start`:
  - Forces S_ADDR_LO and drops `cpu_rst_n` to 0.
  - Clears `done`, `err` and `err_code`, and clears the checksum, counters and pointer.
  - Has priority over a handshake in the same cycle; that byte is discarded.
- `busy` = 1 in S_ADDR_HI through S_VEC_HI, and in S_ADDR_LO after the first byte has been accepted. In practice `busy` = state ∉ {S_ADDR_LO, S_DONE, S_ERR}.

## Timing
- Reset values: state S_ADDR_LO, `cpu_rst_n` = 0, `in_ready` = 1, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `busy` = 0, `done` = 0, `err` = 0, `err_code` = 0.
- Payload write: the loader-side `mem_addr`, `mem_wdata` and `mem_we` are registered. A handshake in cycle N produces `mem_we` = 1 in cycle N+1, and 0 in cycle N+1 when there was no handshake in cycle N.
  - This gives a sustained throughput of 1 byte per cycle.
- `cpu_rst_n` rises the cycle after entering S_DONE. This is at least one cycle after the final RAM write, so the write completes before the CPU fetches.
- `rst` or `start` in the middle of a frame takes effect in the next cycle.
  - A pending registered write still completes in that next cycle.
  - No write is issued after that.

## Configuration
- `PRG_LOADER_VECTOR_EN` defined: S_VEC_LO and S_VEC_HI are compiled in. The reset vector points at the load address, and release is 2 cycles later.
- `PRG_LOADER_VECTOR_EN` undefined: S_CSUM pass goes directly to S_DONE, and RAM outside the payload is never written.

## Structure
- The `ie_defs` package holds:
  - `prg_ld_state_t`, the state enum.
  - `PRG_LD_ERR_NONE`, `PRG_LD_ERR_CSUM` and `PRG_LD_ERR_TIMEOUT`, the 2-bit error codes.
- Sub-module `prg_loader_bus_mux`: the combinational mux selecting between the loader and CPU buses, keyed by `cpu_rst_n`.
- FSM, counters and checksum live in the top module.

## Test plan
- Happy path, vector enabled:
  - Frame 00 80 03 00 A9 01 EA 6C.
  - Required: RAM[8000..8002] = A9 01 EA, RAM[FFFC] = 00, RAM[FFFD] = 80, `done` = 1, `cpu_rst_n` = 1.
- Checksum fail:
  - Same frame with CSUM = 6D.
  - Required: `err` = 1, `err_code` = 1, `cpu_rst_n` stays 0, RAM[FFFC] unchanged.
- Wrap-around:
  - Address FFFE, length 4, bytes 11 22 33 44.
  - Required: RAM[FFFE] = 11, RAM[FFFF] = 22, RAM[0000] = 33, RAM[0001] = 44.
- Zero length:
  - Frame 00 02 00 00 00.
  - Required: no payload writes, `done` = 1.
- Timeout:
  - `TIMEOUT_CYCLES` = 16; stall after LEN_HI.
  - Required: `err_code` = 2 exactly 16 cycles after the last handshake.
- Restart and passthrough:
  - `start` is pulsed mid-payload, then a full valid frame is sent.
  - Required: clean load. After release, `cpu_we` = 1 with `cpu_addr` = 0300 writes RAM[0300].
